// File: rtl/synth_pkg.sv
// synth_pkg: shared definitions for the poly_synth block.
//   - state_t      : frame sequencer states.
//   - inc_lookup() : phase increment per note index, computed for a 24-bit
//                    accumulator at Fs = 100 MHz / 2048 = 48828.125 Hz,
//                    INC[n] = round(220 * 2^((n-1)/12) * 2^24 / Fs), INC[0] = 0.
//   - saturate()   : clamps a signed value to a w-bit two's-complement range.
package synth_pkg;

  localparam int unsigned CLK_HZ         = 100_000_000;
  localparam int unsigned DEF_CHANNELS   = 2;
  localparam int unsigned DEF_VOICES     = 3;
  localparam int unsigned DEF_NOTE_W     = 4;
  localparam int unsigned DEF_SAMPLE_W   = 16;
  localparam int unsigned DEF_PHASE_W    = 24;
  localparam int unsigned DEF_AMP        = 8192;
  localparam int unsigned DEF_SAMPLE_DIV = 2048;

  typedef enum logic [1:0] {IDLE, LOAD, MIX, EMIT} state_t;

  // Note 1 is A3 (220 Hz); each index above is one semitone higher.
  function automatic logic [DEF_PHASE_W-1:0] inc_lookup(input logic [3:0] note);
    case (note)
      4'd0:  return 24'd0;
      4'd1:  return 24'd75591;
      4'd2:  return 24'd80086;
      4'd3:  return 24'd84849;
      4'd4:  return 24'd89894;
      4'd5:  return 24'd95239;
      4'd6:  return 24'd100902;
      4'd7:  return 24'd106902;
      4'd8:  return 24'd113259;
      4'd9:  return 24'd119994;
      4'd10: return 24'd127129;
      4'd11: return 24'd134689;
      4'd12: return 24'd142698;
      4'd13: return 24'd151183;
      4'd14: return 24'd160173;
      default: return 24'd169697;
    endcase
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                  input int unsigned       w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/synth_tick_gen.sv
// synth_tick_gen: sample-rate divider. Counts 0..SAMPLE_DIV-1 and wraps,
// asserting tick for exactly one cycle while the count is SAMPLE_DIV-1.
// Ports:
//   MasterCLK - system clock
//   Reset     - synchronous, active-high reset (count returns to 0)
//   tick      - one-cycle pulse, once every SAMPLE_DIV cycles
module synth_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 2048
) (
  input  logic MasterCLK,
  input  logic Reset,
  output logic tick
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count;

  // NOTE: state registers are updated with <= so every flop samples the
  // pre-edge value of its neighbours; = here would create order-dependent races.
  always_ff @(posedge MasterCLK) begin
    if (Reset)              count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CNT_W'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/poly_synth.sv
// poly_synth: polyphonic square-wave synthesizer. A single phase-accumulator
// engine visits every voice once per output frame, sums +/-AMP per voice into
// a per-channel accumulator, applies a per-channel left shift and saturates.
// Ports:
//   MasterCLK - system clock
//   Reset     - synchronous, active-high reset
//   note_data - note index per voice; voice v of channel c at field c*VOICES+v
//   note_load - captures note_data into the shadow register (any cycle)
//   gain      - per-channel left shift 0..3, channel c at [2c+1:2c]
//   out_data  - channel c at [(c+1)*SAMPLE_W-1 : c*SAMPLE_W], signed
//   out_valid - frame available; held until out_valid && out_ready
//   out_ready - consumer accepts the frame
//   overrun   - sticky: an unaccepted frame was overwritten
module poly_synth
  import synth_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int VOICES     = DEF_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int AMP        = DEF_AMP,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic                           MasterCLK,
  input  logic                           Reset,
  input  logic [CHANNELS*VOICES*NOTE_W-1:0] note_data,
  input  logic                           note_load,
  input  logic [2*CHANNELS-1:0]          gain,
  output logic [CHANNELS*SAMPLE_W-1:0]   out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           overrun
);

  localparam int NV    = CHANNELS * VOICES;
  localparam int ACC_W = SAMPLE_W + $clog2(VOICES) + 4;
  localparam int IDX_W = (NV > 1) ? $clog2(NV) : 1;
  localparam int V_W   = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int C_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t                     state;
  logic [NV*NOTE_W-1:0]       shadow;
  logic [NV*NOTE_W-1:0]       active;
  logic [2*CHANNELS-1:0]      gain_r;
  logic [PHASE_W-1:0]         phase [NV];
  logic signed [ACC_W-1:0]    acc   [CHANNELS];
  logic [IDX_W-1:0]           idx;   // flat voice index
  logic [V_W-1:0]             vox;   // voice within the current channel
  logic [C_W-1:0]             chn;   // channel owning idx (idx / VOICES)
  logic                       tick;

  logic [NOTE_W-1:0]          cur_note;
  logic [PHASE_W-1:0]         new_phase;
  logic signed [ACC_W-1:0]    contrib;
  logic signed [31:0]         scaled    [CHANNELS];
  logic [SAMPLE_W-1:0]        emit_word [CHANNELS];

  synth_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .MasterCLK (MasterCLK),
    .Reset     (Reset),
    .tick      (tick)
  );

  assign cur_note  = active[int'(idx)*NOTE_W +: NOTE_W];
  assign new_phase = phase[idx] + PHASE_W'(inc_lookup(4'(cur_note)));

  // The square's sign follows the MSB of the phase after this frame's step.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path first, so no
    // latch is inferred when a branch forgets to assign it.
    contrib = '0;
    if (cur_note != '0)
      contrib = new_phase[PHASE_W-1] ? -(ACC_W'(AMP)) : ACC_W'(AMP);
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      scaled[c]    = 32'(acc[c]) <<< gain_r[2*c +: 2];
      emit_word[c] = SAMPLE_W'(saturate(scaled[c], SAMPLE_W));
    end
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      state     <= IDLE;
      shadow    <= '0;
      active    <= '0;
      gain_r    <= '0;
      idx       <= '0;
      vox       <= '0;
      chn       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      // NOTE: the phase array is a handful of flops that must start at zero
      // for a deterministic waveform, so it is reset; a true RAM would not be.
      for (int i = 0; i < NV; i++) phase[i] <= '0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else begin
      if (note_load) shadow <= note_data;

      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (tick) begin
            // Notes and gain only change at frame boundaries.
            active <= shadow;
            gain_r <= gain;
            state  <= LOAD;
          end
        end

        LOAD: begin
          for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
          idx   <= '0;
          vox   <= '0;
          chn   <= '0;
          state <= MIX;
        end

        MIX: begin
          phase[idx] <= (cur_note == '0) ? '0 : new_phase;
          acc[chn]   <= acc[chn] + contrib;
          if (idx == IDX_W'(NV - 1)) begin
            state <= EMIT;
          end else begin
            idx <= idx + IDX_W'(1);
            if (vox == V_W'(VOICES - 1)) begin
              vox <= '0;
              chn <= chn + C_W'(1);
            end else begin
              vox <= vox + V_W'(1);
            end
          end
        end

        EMIT: begin
          for (int c = 0; c < CHANNELS; c++)
            out_data[c*SAMPLE_W +: SAMPLE_W] <= emit_word[c];
          // Overrides the acceptance clear above: newest frame is presented.
          out_valid <= 1'b1;
          if (out_valid && !out_ready) overrun <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
